muldiv_ctrl: RTL



---
 rtl/muldiv_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO registers and core stall.
// Define MULDIV_DIV0_FLAG_EN to add the div_zero status pulse output.
module muldiv_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             aluSrc,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] writeData,
  input  logic [WIDTH-1:0] signImm,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MULDIV_DIV0_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  typedef enum logic [1:0] {StIdle, StIter, StFix} stateT;

  stateT              stateQ, stateD;
  logic [CNT_W-1:0]   cntQ, cntD;
  logic [2*WIDTH-1:0] accQ, accD;
  logic [WIDTH-1:0]   bQ, bD;
  logic               isDivQ, isDivD;
  logic               negResQ, negResD;
  logic               negRemQ, negRemD;
  logic               divZeroQ, divZeroD;
  logic [WIDTH-1:0]   hiQ, hiD;
  logic [WIDTH-1:0]   loQ, loD;
  logic               busyQ, doneQ;

  logic [WIDTH-1:0]   bSel, aMag, bMag;
  logic               isSigned, aNeg, bNeg;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     remWide;
  logic               divBorrow;
  logic [WIDTH-1:0]   remNext;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix, remFix;

  assign bSel     = aluSrc ? signImm : writeData;
  assign isSigned = ~op[0];
  assign aNeg     = isSigned & srcA[WIDTH-1];
  assign bNeg     = isSigned & bSel[WIDTH-1];
  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign aMag     = aNeg ? -srcA : srcA;
  assign bMag     = bNeg ? -bSel : bSel;

  // Multiply step: carry out of the upper half lands in the accumulator MSB on shift.
  assign mulSum = accQ[0] ? ({1'b0, accQ[2*WIDTH-1:WIDTH]} + {1'b0, bQ})
                          : {1'b0, accQ[2*WIDTH-1:WIDTH]};

  // Divide step: shifted remainder is WIDTH+1 bits wide before the trial subtract.
  assign remWide   = accQ[2*WIDTH-1:WIDTH-1];
  assign divBorrow = remWide < {1'b0, bQ};
  assign remNext   = divBorrow ? remWide[WIDTH-1:0] : (remWide[WIDTH-1:0] - bQ);

  assign prodFix = negResQ ? -accQ : accQ;
  assign quotFix = negResQ ? -accQ[WIDTH-1:0] : accQ[WIDTH-1:0];
  assign remFix  = negRemQ ? -accQ[2*WIDTH-1:WIDTH] : accQ[2*WIDTH-1:WIDTH];

  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    accD     = accQ;
    bD       = bQ;
    isDivD   = isDivQ;
    negResD  = negResQ;
    negRemD  = negRemQ;
    divZeroD = divZeroQ;
    hiD      = hiQ;
    loD      = loQ;
    case (stateQ)
      StIdle: begin
        if (start) begin
          accD     = {{WIDTH{1'b0}}, aMag};
          bD       = bMag;
          isDivD   = op[1];
          negResD  = aNeg ^ bNeg;
          negRemD  = aNeg;
          cntD     = '0;
          divZeroD = op[1] & (bSel == '0);
          stateD   = (op[1] & (bSel == '0)) ? StFix : StIter;
        end else begin
          if (mthi) hiD = srcA;
          if (mtlo) loD = srcA;
        end
      end
      StIter: begin
        if (isDivQ) begin
          accD = {remNext, accQ[WIDTH-2:0], ~divBorrow};
        end else begin
          accD = {mulSum, accQ[WIDTH-1:1]};
        end
        cntD = cntQ + CNT_W'(1);
        if (cntQ == CNT_W'(WIDTH - 1)) stateD = StFix;
      end
      StFix: begin
        if (!divZeroQ) begin
          if (isDivQ) begin
            loD = quotFix;
            hiD = remFix;
          end else begin
            hiD = prodFix[2*WIDTH-1:WIDTH];
            loD = prodFix[WIDTH-1:0];
          end
        end
        stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ   <= StIdle;
      cntQ     <= '0;
      accQ     <= '0;
      bQ       <= '0;
      isDivQ   <= 1'b0;
      negResQ  <= 1'b0;
      negRemQ  <= 1'b0;
      divZeroQ <= 1'b0;
      hiQ      <= '0;
      loQ      <= '0;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      accQ     <= accD;
      bQ       <= bD;
      isDivQ   <= isDivD;
      negResQ  <= negResD;
      negRemQ  <= negRemD;
      divZeroQ <= divZeroD;
      hiQ      <= hiD;
      loQ      <= loD;
      busyQ    <= (stateD != StIdle);
      doneQ    <= (stateQ == StFix);
    end
  end

`ifdef MULDIV_DIV0_FLAG_EN
  logic divZeroPulseQ;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      divZeroPulseQ <= 1'b0;
    end else begin
      divZeroPulseQ <= (stateQ == StFix) & divZeroQ;
    end
  end

  assign div_zero = divZeroPulseQ;
`endif

  assign stall = (stateQ != StIdle) | start;
  assign busy  = busyQ;
  assign done  = doneQ;
  assign hi    = hiQ;
  assign lo    = loQ;

endmodule
